// File: rtl/irq_source_if.sv
// Bus-side port bundle of the irq_source peripheral: address, byte-enabled
// write data and combinational read data.
interface irq_source_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output byteen, output wdata, input rdata);
    modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/irq_source.sv
// Memory-mapped interrupt source: raises irq on a one-shot PC match or on
// expiry of a programmable countdown, and holds it until a store to STAT.
module irq_source #(
    parameter logic [31:0] BASE         = 32'h0000_7f20,
    parameter logic [31:0] RESET_TARGET = 32'h0000_3018,
    parameter bit          ARM_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    irq_source_if.slave  bus,
    input  logic [31:0]  pc,
    output logic         irq
);

    typedef enum logic [1:0] {
        OFF_STAT   = 2'd0,
        OFF_TARGET = 2'd1,
        OFF_PRESET = 2'd2,
        OFF_COUNT  = 2'd3
    } reg_off_t;

    // S_WAIT is the timer flag: COUNT has expired and is waiting for the ACK.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic [31:0] preset;
    logic [31:0] count;
    logic        armed;
    logic        pending;

    logic        sel;
    reg_off_t    off;
    logic        ack;
    logic        target_wr;
    logic        preset_wr;
    logic        pc_hit;
    logic        timer_fire;
    logic [31:0] target_new;
    logic [31:0] preset_new;
    logic        unused_addr_lsb;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] data,
                                          input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? data[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign sel             = (bus.addr[31:4] == BASE[31:4]);
    assign off             = reg_off_t'(bus.addr[3:2]);
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign ack       = sel && (bus.byteen != 4'b0) && (off == OFF_STAT);
    assign target_wr = sel && (bus.byteen != 4'b0) && (off == OFF_TARGET);
    assign preset_wr = sel && (bus.byteen != 4'b0) && (off == OFF_PRESET);

    assign target_new = merge(target, bus.wdata, bus.byteen) & ~32'h3;
    assign preset_new = merge(preset, bus.wdata, bus.byteen);

    assign pc_hit     = armed && ((pc & ~32'h3) == target);
    // A PRESET write in the last RUN cycle replaces COUNT, so no expiry then.
    assign timer_fire = (state == S_RUN) && !preset_wr && (count == 32'd1);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            target  <= RESET_TARGET;
            armed   <= ARM_ON_RESET;
            preset  <= 32'd0;
            count   <= 32'd0;
            pending <= 1'b0;
        end else begin
            pending <= (pending && !ack) || pc_hit || timer_fire;

            if (target_wr) begin
                target <= target_new;
                armed  <= 1'b1;
            end else if (pc_hit) begin
                armed  <= 1'b0;
            end

            if (preset_wr) begin
                preset <= preset_new;
            end

            case (state)
                S_IDLE, S_RUN: begin
                    if (preset_wr) begin
                        count <= preset_new;
                        state <= (preset_new != 32'd0) ? S_RUN : S_IDLE;
                    end else if (state == S_RUN) begin
                        count <= count - 32'd1;
                        if (count == 32'd1) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        count <= preset;
                        state <= (preset != 32'd0) ? S_RUN : S_IDLE;
                    end else if (preset_wr) begin
                        count <= preset_new;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign irq = pending;

    always_comb begin
        bus.rdata = 32'd0;
        if (sel) begin
            case (off)
                OFF_STAT:   bus.rdata = {30'd0, pending, armed};
                OFF_TARGET: bus.rdata = target;
                OFF_PRESET: bus.rdata = preset;
                OFF_COUNT:  bus.rdata = count;
                default:    bus.rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_source.sv
// Scoreboard bench for irq_source: stimulus queues hand-computed expectations,
// a monitor process pops and compares them whenever a probe is raised.
`timescale 1ns/1ps
module tb_irq_source;

    localparam logic [31:0] A_STAT   = 32'h0000_7f20;
    localparam logic [31:0] A_TARGET = 32'h0000_7f24;
    localparam logic [31:0] A_PRESET = 32'h0000_7f28;
    localparam logic [31:0] A_COUNT  = 32'h0000_7f2c;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        irq;

    irq_source_if bus ();

    irq_source dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .pc    (pc),
        .irq   (irq)
    );

    typedef struct {
        string       name;
        bit          is_rd;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    event      probe_ev;
    int        n_checks = 0;
    int        n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compares each queued expectation against what the DUT presents.
    initial begin
        sb_entry_t   e;
        logic [31:0] obs;
        forever begin
            @(probe_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                obs = e.is_rd ? bus.rdata : {31'd0, irq};
                n_checks++;
                if (obs !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.addr   = a;
        bus.byteen = be;
        bus.wdata  = d;
        step();
        bus.byteen = 4'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] v);
        sb_entry_t e;
        bus.addr   = a;
        bus.byteen = 4'b0;
        e.name = name; e.is_rd = 1'b1; e.exp = v;
        sb.push_back(e);
        #1 -> probe_ev;
        #1;
    endtask

    task automatic chk_irq(input string name, input logic v);
        sb_entry_t e;
        e.name = name; e.is_rd = 1'b0; e.exp = {31'd0, v};
        sb.push_back(e);
        #1 -> probe_ev;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        pc         = 32'd0;
        bus.addr   = 32'd0;
        bus.byteen = 4'b0;
        bus.wdata  = 32'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk_irq("rst_irq", 1'b0);
        chk_rd("rst_stat", A_STAT, 32'h1);
        chk_rd("rst_target", A_TARGET, 32'h3018);
        chk_rd("rst_count", A_COUNT, 32'h0);

        // PC approaching the target does not trigger
        for (int p = 32'h3000; p <= 32'h3014; p += 4) begin
            pc = p;
            step();
            chk_irq("pc_near", 1'b0);
        end
        chk_rd("pc_near_stat", A_STAT, 32'h1);

        // Match with low bits set; one cycle latency
        pc = 32'h301a;
        step();
        chk_irq("pc_hit_irq", 1'b1);
        chk_rd("pc_hit_stat", A_STAT, 32'h2);
        pc = 32'd0;
        wr(A_STAT, 4'hf, 32'hdead_beef);
        chk_irq("ack_irq", 1'b0);
        chk_rd("ack_stat", A_STAT, 32'h0);
        pc = 32'h3018;
        step();
        step();
        chk_irq("no_retrigger", 1'b0);
        pc = 32'd0;

        // Byte-merged TARGET write re-arms
        wr(A_TARGET, 4'b0011, 32'hffff_3100);
        chk_rd("tgt_merge", A_TARGET, 32'h3100);
        chk_rd("tgt_armed", A_STAT, 32'h1);
        pc = 32'h3100;
        step();
        chk_irq("tgt_hit", 1'b1);
        pc = 32'd0;
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("tgt_ack", 1'b0);

        // Countdown of 5
        wr(A_PRESET, 4'hf, 32'd5);
        chk_rd("cnt_load", A_COUNT, 32'd5);
        chk_rd("preset_rd", A_PRESET, 32'd5);
        chk_irq("cnt_load_irq", 1'b0);
        for (int k = 4; k >= 1; k--) begin
            step();
            chk_rd("cnt_dec", A_COUNT, k);
            chk_irq("cnt_dec_irq", 1'b0);
        end
        step();
        chk_rd("cnt_zero", A_COUNT, 32'd0);
        chk_irq("cnt_fire", 1'b1);
        step();
        chk_rd("cnt_hold", A_COUNT, 32'd0);
        chk_irq("cnt_hold_irq", 1'b1);
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("cnt_ack", 1'b0);
        chk_rd("cnt_reload", A_COUNT, 32'd5);
        step();
        chk_rd("cnt_rerun", A_COUNT, 32'd4);

        // PRESET=0 during RUN stops the timer
        wr(A_PRESET, 4'hf, 32'd0);
        chk_rd("stop_count", A_COUNT, 32'd0);
        for (int k = 0; k < 6; k++) step();
        chk_irq("stop_irq", 1'b0);
        chk_rd("stop_count2", A_COUNT, 32'd0);

        // Set beats clear: ACK together with a PC match
        wr(A_TARGET, 4'hf, 32'h3200);
        pc = 32'h3200;
        step();
        chk_irq("sbc_first", 1'b1);
        pc = 32'd0;
        wr(A_TARGET, 4'hf, 32'h3300);
        chk_rd("sbc_stat3", A_STAT, 32'h3);
        pc = 32'h3300;
        wr(A_STAT, 4'b0001, 32'd0);
        chk_irq("sbc_keep", 1'b1);
        chk_rd("sbc_stat2", A_STAT, 32'h2);
        pc = 32'd0;
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("sbc_clear", 1'b0);

        // Match in the TARGET-write cycle uses old TARGET/armed
        pc = 32'h3400;
        wr(A_TARGET, 4'hf, 32'h3400);
        chk_irq("old_tgt_irq", 1'b0);
        chk_rd("old_tgt_stat", A_STAT, 32'h1);
        step();
        chk_irq("new_tgt_irq", 1'b1);
        pc = 32'd0;
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("new_tgt_ack", 1'b0);

        // PRESET write during WAIT loads COUNT but holds until ACK
        wr(A_PRESET, 4'hf, 32'd2);
        step();
        chk_rd("w_cnt1", A_COUNT, 32'd1);
        step();
        chk_irq("w_fire", 1'b1);
        wr(A_PRESET, 4'hf, 32'd7);
        chk_rd("w_load", A_COUNT, 32'd7);
        step();
        chk_rd("w_hold", A_COUNT, 32'd7);
        chk_irq("w_hold_irq", 1'b1);
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("w_ack", 1'b0);
        chk_rd("w_reload", A_COUNT, 32'd7);
        step();
        chk_rd("w_rerun", A_COUNT, 32'd6);

        // Reset while irq is high and the timer is running
        wr(A_TARGET, 4'hf, 32'h3500);
        pc = 32'h3500;
        step();
        chk_irq("pre_rst_irq", 1'b1);
        reset = 1'b1;
        pc    = 32'd0;
        step();
        reset = 1'b0;
        chk_irq("rst2_irq", 1'b0);
        chk_rd("rst2_stat", A_STAT, 32'h1);
        chk_rd("rst2_target", A_TARGET, 32'h3018);
        chk_rd("rst2_preset", A_PRESET, 32'h0);
        step();
        chk_rd("rst2_count", A_COUNT, 32'h0);

        // Decode boundaries and non-ACK accesses
        chk_rd("oor_hi", 32'h7f30, 32'h0);
        chk_rd("oor_lo", 32'h7f1c, 32'h0);
        wr(A_PRESET, 4'hf, 32'd9);
        wr(A_COUNT, 4'hf, 32'h55);
        chk_rd("count_ro", A_COUNT, 32'd8);
        wr(A_PRESET, 4'hf, 32'd0);
        pc = 32'h3018;
        step();
        chk_irq("be0_setup", 1'b1);
        pc         = 32'd0;
        bus.addr   = A_STAT;
        bus.byteen = 4'b0;
        step();
        chk_irq("be0_no_ack", 1'b1);
        wr(32'h7f30, 4'hf, 32'd0);
        chk_irq("oor_no_ack", 1'b1);
        wr(A_STAT, 4'hf, 32'd0);
        chk_irq("final_ack", 1'b0);

        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
